// File: rtl/if_branch_predictor_if.sv
// Fetch/prediction, resolve/update and performance-counter signals of the IF-stage branch predictor.
// The predictor takes the slave modport; the pipeline side takes the master modport.
interface if_branch_predictor_if #(
    parameter int GHR_W = 4
);
    logic             fetch_valid;
    logic [31:0]      fetch_pc;
    logic             fetch_br;
    logic             fetch_jal;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             pred_hit;
    logic [GHR_W-1:0] pred_ghr;

    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_is_br;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic [GHR_W-1:0] upd_ghr;
    logic             upd_mispredict;

    logic [31:0]      perf_br_cnt;
    logic [31:0]      perf_miss_cnt;

    modport master (
        output fetch_valid, fetch_pc, fetch_br, fetch_jal,
        output upd_valid, upd_pc, upd_is_br, upd_taken, upd_target, upd_ghr, upd_mispredict,
        input  pred_taken, pred_target, pred_hit, pred_ghr,
        input  perf_br_cnt, perf_miss_cnt
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_br, fetch_jal,
        input  upd_valid, upd_pc, upd_is_br, upd_taken, upd_target, upd_ghr, upd_mispredict,
        output pred_taken, pred_target, pred_hit, pred_ghr,
        output perf_br_cnt, perf_miss_cnt
    );
endinterface

// File: rtl/if_branch_predictor.sv
// gshare direction predictor with a direct-mapped BTB and a speculative global history
// that the resolving stage repairs from the snapshot carried down the pipeline.
module if_branch_predictor #(
    parameter int BHT_IDX = 7,
    parameter int GHR_W   = 4,
    parameter int CTR_W   = 2,
    parameter int BTB_IDX = 5,
    parameter int TAG_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    if_branch_predictor_if.slave  bp
);
    localparam int BHT_N = 1 << BHT_IDX;
    localparam int BTB_N = 1 << BTB_IDX;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_MAX >> 1;

    logic [CTR_W-1:0]  bht_reg        [BHT_N];
    logic [BTB_N-1:0]  btb_valid_reg;
    logic [TAG_W-1:0]  btb_tag_reg    [BTB_N];
    logic [31:0]       btb_target_reg [BTB_N];
    logic [GHR_W-1:0]  ghr_reg, ghr_next;
    logic [31:0]       perf_br_reg, perf_miss_reg;

    logic [BHT_IDX-1:0] fetch_ghr_ext, upd_ghr_ext;
    logic [BHT_IDX-1:0] fetch_bht_idx, upd_bht_idx;
    logic [BTB_IDX-1:0] fetch_btb_idx, upd_btb_idx;
    logic [TAG_W-1:0]   fetch_tag, upd_tag;
    logic [CTR_W-1:0]   fetch_ctr, upd_ctr, upd_ctr_next;
    logic [GHR_W-1:0]   fetch_shift, repair_shift;
    logic               btb_hit;

    always_comb begin
        fetch_ghr_ext = '0;
        fetch_ghr_ext[GHR_W-1:0] = ghr_reg;
        upd_ghr_ext = '0;
        upd_ghr_ext[GHR_W-1:0] = bp.upd_ghr;
    end

    assign fetch_bht_idx = bp.fetch_pc[BHT_IDX+1:2] ^ fetch_ghr_ext;
    assign upd_bht_idx   = bp.upd_pc[BHT_IDX+1:2] ^ upd_ghr_ext;
    assign fetch_btb_idx = bp.fetch_pc[BTB_IDX+1:2];
    assign upd_btb_idx   = bp.upd_pc[BTB_IDX+1:2];
    assign fetch_tag     = bp.fetch_pc[BTB_IDX+TAG_W+1:BTB_IDX+2];
    assign upd_tag       = bp.upd_pc[BTB_IDX+TAG_W+1:BTB_IDX+2];
    assign fetch_ctr     = bht_reg[fetch_bht_idx];
    assign upd_ctr       = bht_reg[upd_bht_idx];

    // Prediction reads only registered state, so a same-cycle update is seen one cycle later.
    assign btb_hit          = btb_valid_reg[fetch_btb_idx] && (btb_tag_reg[fetch_btb_idx] == fetch_tag);
    assign bp.pred_hit      = btb_hit;
    assign bp.pred_taken    = btb_hit && (bp.fetch_jal || (bp.fetch_br && fetch_ctr[CTR_W-1]));
    assign bp.pred_target   = bp.pred_taken ? btb_target_reg[fetch_btb_idx] : bp.fetch_pc + 32'd4;
    assign bp.pred_ghr      = ghr_reg;
    assign bp.perf_br_cnt   = perf_br_reg;
    assign bp.perf_miss_cnt = perf_miss_reg;

    // A one-bit history has nothing to shift out; it simply takes the new outcome.
    generate
        if (GHR_W == 1) begin : g_ghr_bit
            assign fetch_shift  = bp.pred_taken;
            assign repair_shift = bp.upd_taken;
        end else begin : g_ghr_shift
            assign fetch_shift  = {ghr_reg[GHR_W-2:0], bp.pred_taken};
            assign repair_shift = {bp.upd_ghr[GHR_W-2:0], bp.upd_taken};
        end
    endgenerate

    always_comb begin
        ghr_next = ghr_reg;
        if (bp.upd_valid && bp.upd_mispredict) begin
            ghr_next = bp.upd_is_br ? repair_shift : bp.upd_ghr;
        end else if (bp.fetch_valid && bp.fetch_br) begin
            ghr_next = fetch_shift;
        end
    end

    always_comb begin
        upd_ctr_next = upd_ctr;
        if (bp.upd_taken) begin
            if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + CTR_W'(1);
        end else begin
            if (upd_ctr != '0) upd_ctr_next = upd_ctr - CTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) bht_reg[i] <= CTR_INIT;
            btb_valid_reg <= '0;
            ghr_reg       <= '0;
            perf_br_reg   <= '0;
            perf_miss_reg <= '0;
        end else begin
            if (bp.upd_valid && bp.upd_is_br) bht_reg[upd_bht_idx] <= upd_ctr_next;
            if (bp.upd_valid && bp.upd_taken) btb_valid_reg[upd_btb_idx] <= 1'b1;
            ghr_reg       <= ghr_next;
            perf_br_reg   <= perf_br_reg + 32'(bp.upd_valid && bp.upd_is_br);
            perf_miss_reg <= perf_miss_reg + 32'(bp.upd_valid && bp.upd_mispredict);
        end
    end

    // Tag/target payload needs no reset: the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (!rst && bp.upd_valid && bp.upd_taken) begin
            btb_tag_reg[upd_btb_idx]    <= upd_tag;
            btb_target_reg[upd_btb_idx] <= bp.upd_target;
        end
    end
endmodule

// File: tb/tb_if_branch_predictor.sv
// Scoreboarded bench for if_branch_predictor: directed scenarios followed by random traffic,
// predicted against a table-level model of the gshare/BTB/history rules.
module tb_if_branch_predictor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_branch_predictor_if #(.GHR_W(4)) bp ();

    if_branch_predictor #(
        .BHT_IDX(7), .GHR_W(4), .CTR_W(2), .BTB_IDX(5), .TAG_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp.slave)
    );

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic        hit;
        logic [3:0]  ghr;
        logic [31:0] br_cnt;
        logic [31:0] miss_cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_txn  = 0;

    // Reference state: plain integers per table entry.
    int unsigned m_ctr   [128];
    bit          m_bv    [32];
    int unsigned m_btag  [32];
    logic [31:0] m_btgt  [32];
    int unsigned m_ghr;
    logic [31:0] m_br, m_miss;

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_ctr[i] = 1;
        for (int i = 0; i < 32; i++) m_bv[i] = 1'b0;
        m_ghr  = 0;
        m_br   = 0;
        m_miss = 0;
    endtask

    task automatic drive(input bit r, input bit fv, input bit [31:0] pc, input bit br, input bit jal,
                         input bit uv, input bit [31:0] upc, input bit uisbr, input bit ut,
                         input bit [31:0] utgt, input bit [3:0] ughr, input bit umis);
        exp_t e;
        int unsigned bi, ti, ui, uti;
        @(posedge clk);
        #1;
        rst               = r;
        bp.fetch_valid    = fv;
        bp.fetch_pc       = pc;
        bp.fetch_br       = br;
        bp.fetch_jal      = jal;
        bp.upd_valid      = uv;
        bp.upd_pc         = upc;
        bp.upd_is_br      = uisbr;
        bp.upd_taken      = ut;
        bp.upd_target     = utgt;
        bp.upd_ghr        = ughr;
        bp.upd_mispredict = umis;

        bi = ((pc >> 2) ^ m_ghr) % 128;
        ti = (pc >> 2) % 32;
        e.hit      = m_bv[ti] && (m_btag[ti] == (pc >> 7) % 256);
        e.taken    = e.hit && (jal || (br && m_ctr[bi] >= 2));
        e.target   = e.taken ? m_btgt[ti] : pc + 32'd4;
        e.ghr      = 4'(m_ghr);
        e.br_cnt   = m_br;
        e.miss_cnt = m_miss;
        sb_q.push_back(e);

        if (r) begin
            model_reset();
        end else begin
            if (uv && uisbr) begin
                ui = ((upc >> 2) ^ ughr) % 128;
                if (ut) m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                else    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                m_br = m_br + 1;
            end
            if (uv && ut) begin
                uti = (upc >> 2) % 32;
                m_bv[uti]   = 1'b1;
                m_btag[uti] = (upc >> 7) % 256;
                m_btgt[uti] = utgt;
            end
            if (uv && umis) m_miss = m_miss + 1;
            if (uv && umis)     m_ghr = uisbr ? ((ughr * 2) + ut) % 16 : ughr;
            else if (fv && br)  m_ghr = ((m_ghr * 2) + e.taken) % 16;
        end
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL txn %0d %s: got %08h expected %08h", n_txn, nm, act, exp);
        end
    endtask

    // Monitor: the prediction is combinational, so every driven cycle yields one response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pred_taken", 32'(bp.pred_taken), 32'(e.taken));
                check("pred_target", bp.pred_target, e.target);
                check("pred_hit", 32'(bp.pred_hit), 32'(e.hit));
                check("pred_ghr", 32'(bp.pred_ghr), 32'(e.ghr));
                check("perf_br_cnt", bp.perf_br_cnt, e.br_cnt);
                check("perf_miss_cnt", bp.perf_miss_cnt, e.miss_cnt);
                $display("txn %0d pc=%08h taken=%0b target=%08h hit=%0b ghr=%h br=%0d miss=%0d",
                         n_txn, bp.fetch_pc, bp.pred_taken, bp.pred_target, bp.pred_hit,
                         bp.pred_ghr, bp.perf_br_cnt, bp.perf_miss_cnt);
                n_txn++;
            end
        end
    end

    function automatic bit [31:0] rand_pc();
        return 32'h100 + ($urandom_range(0, 15) << 2) + ($urandom_range(0, 1) << 12);
    endfunction

    initial begin
        bit fv, br, jal, uv, uisbr, ut, umis, r;
        int wait_cycles;
        rst = 1'b1;
        bp.fetch_valid = 0; bp.fetch_pc = 0; bp.fetch_br = 0; bp.fetch_jal = 0;
        bp.upd_valid = 0; bp.upd_pc = 0; bp.upd_is_br = 0; bp.upd_taken = 0;
        bp.upd_target = 0; bp.upd_ghr = 0; bp.upd_mispredict = 0;
        model_reset();
        @(posedge clk);
        // Reset: outputs before the first reset edge are unknown, so start checking after it.
        drive(1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0);
        sb_q.delete();
        drive(1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0);

        // Post-reset fetch of a branch, then the history it left behind.
        drive(0, 1, 32'h60, 1, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0);
        idle();

        // Train pc 0x100 taken twice, then predict it.
        repeat (2) drive(0, 0, 32'h0, 0, 0, 1, 32'h100, 1, 1, 32'h200, 4'h0, 0);
        drive(0, 0, 32'h100, 1, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0);

        // Five not-taken updates saturate the counter at zero.
        repeat (5) drive(0, 0, 32'h100, 1, 0, 1, 32'h100, 1, 0, 32'h0, 4'h0, 0);
        drive(0, 0, 32'h100, 1, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0);

        // History repair: set 0111, then a branch mispredict beats a same-cycle fetch shift.
        drive(0, 0, 32'h0, 0, 0, 1, 32'h300, 0, 1, 32'h340, 4'b0111, 1);
        drive(0, 1, 32'h80, 1, 0, 1, 32'h180, 1, 0, 32'h0, 4'b0001, 1);
        idle();

        // jal resolved as mispredicted, then fetched again.
        drive(0, 0, 32'h0, 0, 0, 1, 32'h500, 0, 1, 32'h4000, 4'b0101, 1);
        drive(0, 1, 32'h500, 0, 1, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0);

        // Mispredict counter wrap.
        idle();
        @(negedge clk);
        #1;
        force dut.perf_miss_reg = 32'hFFFF_FFFF;
        #1;
        release dut.perf_miss_reg;
        m_miss = 32'hFFFF_FFFF;
        drive(0, 0, 32'h0, 0, 0, 1, 32'h600, 0, 1, 32'h700, 4'h3, 1);
        idle();

        // Mid-stream reset with an update that must be ignored, then the BTB is empty.
        drive(1, 1, 32'h500, 0, 1, 1, 32'h500, 1, 1, 32'h900, 4'h2, 1);
        drive(0, 1, 32'h500, 0, 1, 0, 32'h0, 0, 0, 32'h0, 4'h0, 0);

        for (int k = 0; k < 1500; k++) begin
            r     = ($urandom_range(0, 499) == 0);
            fv    = ($urandom_range(0, 9) < 8);
            jal   = ($urandom_range(0, 9) == 0);
            br    = !jal && ($urandom_range(0, 1) == 1);
            uv    = ($urandom_range(0, 1) == 1);
            uisbr = ($urandom_range(0, 9) < 7);
            ut    = uisbr ? ($urandom_range(0, 1) == 1) : 1'b1;
            umis  = ($urandom_range(0, 3) == 0);
            drive(r, fv, rand_pc(), br, jal, uv, rand_pc(), uisbr, ut,
                  32'($urandom) & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)), umis);
        end

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d responses still pending, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
